// File: rtl/fml_pkg.sv
// Shared definitions for the FML DMA reader.
// Burst geometry, address alignment helpers and reader FSM states.
package fml_pkg;

   localparam int FML_BURST_LEN = 4;
   localparam int BEAT_W        = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SPACE,
      REQ,
      BEATS
   } rd_state_e;

   function automatic int burst_bytes(input int dw);
      return FML_BURST_LEN * dw / 8;
   endfunction

   function automatic int align_w(input int dw);
      return $clog2(burst_bytes(dw));
   endfunction

endpackage

// File: rtl/fml_sync_fifo.sv
// First-word-fall-through FIFO holding captured read beats.
// Head is valid whenever empty is low; pops on an empty FIFO are dropped.
module fml_sync_fifo #(
   parameter int DW    = 64,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop_ok;

   assign empty  = (count == '0);
   assign pop_ok = pop & ~empty;
   assign head   = mem[rd_ptr];

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge sys_clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (
      @(posedge sys_clk) disable iff (!sys_rst_n)
      !(push && !pop_ok && count == CW'(DEPTH))
   );

endmodule

// File: rtl/fml_dma_reader.sv
// FML master streaming a contiguous region as 4-beat read bursts.
// A burst is only requested once the FIFO can absorb all of its beats.
module fml_dma_reader
   import fml_pkg::*;
#(
   parameter int FML_DEPTH  = 26,
   parameter int DW         = 64,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 start,
   input  logic [FML_DEPTH-1:0] base_adr,
   input  logic [CNT_W-1:0]     nbursts,
   output logic                 busy,
   output logic                 done,
   output logic [FML_DEPTH-1:0] fml_adr,
   output logic                 fml_stb,
   output logic                 fml_we,
   output logic [DW/8-1:0]      fml_sel,
   input  logic                 fml_ack,
   input  logic [DW-1:0]        fml_di,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   input  logic                 out_ready
);

   localparam int BB = burst_bytes(DW);
   localparam int AW = align_w(DW);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] SPACE_LIM =
      CW'(FIFO_DEPTH - FML_BURST_LEN);
   localparam logic [FML_DEPTH-1:0] ADR_MASK =
      ~FML_DEPTH'((1 << AW) - 1);

   rd_state_e            state_q, state_d;
   logic [FML_DEPTH-1:0] adr_q;
   logic [CNT_W-1:0]     rem_q;
   logic [BEAT_W-1:0]    beat_q;
   logic                 stb_q;
   logic                 done_q;
   logic                 done_d;
   logic                 load;
   logic                 last;
   logic                 push;
   logic                 empty;
   logic [CW-1:0]        fifo_cnt;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign fml_adr   = adr_q;
   assign fml_stb   = stb_q;
   assign fml_we    = 1'b0;
   assign fml_sel   = '1;
   assign out_valid = ~empty;

   // Next-state decode: reserve space, request, then capture 4 beats.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      load    = 1'b0;
      last    = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (nbursts == '0) begin
                  done_d = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_d = WAIT_SPACE;
               end
            end
         end
         WAIT_SPACE: begin
            if (fifo_cnt <= SPACE_LIM)
               state_d = REQ;
         end
         REQ: begin
            if (fml_ack) begin
               push    = 1'b1;
               state_d = BEATS;
            end
         end
         BEATS: begin
            push = 1'b1;
            if (beat_q == BEAT_W'(FML_BURST_LEN - 1)) begin
               last = 1'b1;
               if (rem_q == CNT_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_SPACE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, registered strobe, address and burst/beat counters.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
         adr_q   <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         stb_q   <= (state_d == REQ);
         done_q  <= done_d;
         if (load) begin
            adr_q <= base_adr & ADR_MASK;
            rem_q <= nbursts;
         end else if (last) begin
            adr_q <= adr_q + FML_DEPTH'(BB);
            rem_q <= rem_q - CNT_W'(1);
         end
         if (state_q == BEATS)
            beat_q <= beat_q + BEAT_W'(1);
         else
            beat_q <= BEAT_W'(1);
      end
   end

   fml_sync_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (push),
      .push_data (fml_di),
      .pop       (out_ready),
      .head      (out_data),
      .empty     (empty),
      .count     (fifo_cnt)
   );

endmodule

// File: tb/tb_fml_dma_reader.sv
// Bench for fml_dma_reader: FML memory responder plus stream scoreboard.
// Expected addresses are queued by stimulus; expected words by the responder.
module tb_fml_dma_reader;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        start = 1'b0;
   logic [25:0] base_adr = '0;
   logic [15:0] nbursts = '0;
   logic        busy, done;
   logic [25:0] fml_adr;
   logic        fml_stb, fml_we;
   logic [7:0]  fml_sel;
   logic        fml_ack;
   logic        rsp_ack = 1'b0;
   logic        spur_ack = 1'b0;
   logic [63:0] fml_di = '0;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready = 1'b0;

   int tests = 0;
   int fails = 0;
   int words, bursts, dones, stbs;

   logic [25:0] exp_adr [$];
   logic [63:0] exp_data [$];

   assign fml_ack = rsp_ack | spur_ack;

   always #5 sys_clk = ~sys_clk;

   fml_dma_reader dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .base_adr  (base_adr),
      .nbursts   (nbursts),
      .busy      (busy),
      .done      (done),
      .fml_adr   (fml_adr),
      .fml_stb   (fml_stb),
      .fml_we    (fml_we),
      .fml_sel   (fml_sel),
      .fml_ack   (fml_ack),
      .fml_di    (fml_di),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   function automatic logic [63:0] word(input logic [25:0] a,
                                        input int b);
      return {6'd0, a, 24'hC0FFEE, 6'd0, b[1:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stream monitor: pops the scoreboard on every accepted word.
   always @(negedge sys_clk) begin
      if (out_valid && out_ready) begin
         words++;
         if (exp_data.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_word: got %0h expected none", out_data);
         end else begin
            chk("out_data", out_data, exp_data.pop_front());
         end
      end
      if (done)
         dones++;
      if (fml_stb)
         stbs++;
   end

   // Memory responder: acks 3 cycles after strobe, then 3 more beats.
   initial begin
      logic [25:0] a;
      logic [25:0] cur;
      forever begin
         @(posedge sys_clk); #1;
         if (fml_stb && sys_rst_n) begin
            repeat (2) begin @(posedge sys_clk); #1; end
            chk("stb_held", fml_stb, 1'b1);
            if (exp_adr.size() == 0) begin
               a = '1;
               tests++;
               fails++;
               $display("FAIL extra_burst: got %0h expected none", fml_adr);
            end else begin
               a = exp_adr.pop_front();
               chk("fml_adr", fml_adr, a);
            end
            cur = fml_adr;
            bursts++;
            rsp_ack = 1'b1;
            fml_di  = word(cur, 0);
            exp_data.push_back(word(a, 0));
            for (int b = 1; b < 4; b++) begin
               @(posedge sys_clk); #1;
               rsp_ack = 1'b0;
               if (!sys_rst_n) break;
               fml_di = word(cur, b);
               exp_data.push_back(word(a, b));
            end
            rsp_ack = 1'b0;
         end
      end
   end

   task automatic clr();
      words = 0; bursts = 0; dones = 0; stbs = 0;
   endtask

   task automatic go(input logic [25:0] a, input logic [15:0] n);
      @(posedge sys_clk); #1;
      base_adr = a; nbursts = n; start = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0; base_adr = 26'h155_5555; nbursts = 16'h7777;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (done) begin seen = 1'b1; break; end
      end
      chk("done_seen", seen, 1'b1);
      if (seen) chk("busy_at_done", busy, 1'b0);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (exp_data.size() == 0 && !out_valid) break;
      end
      chk("drained", 64'(exp_data.size()), 0);
   endtask

   initial begin
      bit seen;
      clr();
      // Reset values
      repeat (3) @(posedge sys_clk); #1;
      chk("rst_stb", fml_stb, 0);
      chk("rst_adr", fml_adr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      sys_rst_n = 1'b1;

      // Basic two-burst read
      clr(); out_ready = 1'b1;
      exp_adr.push_back(26'h100); exp_adr.push_back(26'h120);
      go(26'h100, 2);
      wait_done(200);
      wait_drain();
      chk("basic_words", words, 8);
      chk("basic_bursts", bursts, 2);
      chk("basic_dones", dones, 1);
      chk("basic_busy", busy, 0);

      // Backpressure: only two bursts fit
      clr(); out_ready = 1'b0;
      exp_adr.push_back(26'h400); exp_adr.push_back(26'h420);
      exp_adr.push_back(26'h440); exp_adr.push_back(26'h460);
      go(26'h400, 4);
      repeat (60) @(negedge sys_clk);
      chk("bp_bursts", bursts, 2);
      chk("bp_count", dut.fifo_cnt, 8);
      chk("bp_stb", fml_stb, 0);
      chk("bp_busy", busy, 1);
      @(posedge sys_clk); #1; out_ready = 1'b1;
      wait_done(400);
      wait_drain();
      chk("bp_words", words, 16);
      chk("bp_bursts_all", bursts, 4);

      // Zero burst count
      clr();
      go(26'h200, 0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      @(posedge sys_clk); #1;
      chk("zero_done_pulse", done, 0);
      repeat (10) @(negedge sys_clk);
      chk("zero_stbs", stbs, 0);
      chk("zero_dones", dones, 1);

      // Address wrap, unaligned base
      clr();
      exp_adr.push_back(26'h3FF_FFE0); exp_adr.push_back(26'h000_0000);
      go(26'h3FF_FFE5, 2);
      wait_done(200);
      wait_drain();
      chk("wrap_words", words, 8);

      // Start while busy and spurious ack are ignored
      clr(); out_ready = 1'b0;
      exp_adr.push_back(26'h800); exp_adr.push_back(26'h820);
      exp_adr.push_back(26'h840);
      go(26'h800, 3);
      repeat (40) @(negedge sys_clk);
      @(posedge sys_clk); #1;
      start = 1'b1; nbursts = 16'd9; base_adr = '0; spur_ack = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0; spur_ack = 1'b0;
      repeat (10) @(negedge sys_clk);
      chk("ign_bursts", bursts, 2);
      chk("ign_count", dut.fifo_cnt, 8);
      chk("ign_stb", fml_stb, 0);
      @(posedge sys_clk); #1; out_ready = 1'b1;
      wait_done(400);
      wait_drain();
      chk("ign_words", words, 12);
      chk("ign_bursts_all", bursts, 3);
      chk("ign_dones", dones, 1);

      // Reset in the middle of a burst
      clr(); out_ready = 1'b0;
      exp_adr.push_back(26'h1000);
      go(26'h1000, 1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge sys_clk);
         if (fml_ack) begin seen = 1'b1; break; end
      end
      chk("rst_ack_seen", seen, 1);
      @(posedge sys_clk);
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("valid_before_rst", out_valid, 1);
      sys_rst_n = 1'b0;
      #1;
      chk("mid_stb", fml_stb, 0);
      chk("mid_valid", out_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_count", dut.fifo_cnt, 0);
      repeat (3) @(posedge sys_clk); #1;
      exp_data.delete(); exp_adr.delete();
      sys_rst_n = 1'b1;
      clr(); out_ready = 1'b1;
      exp_adr.push_back(26'h2000);
      go(26'h2000, 1);
      wait_done(200);
      wait_drain();
      chk("post_words", words, 4);
      chk("post_bursts", bursts, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
